// File: rtl/fp32_pkg.sv
// FP32 field layout and constants shared by the approximate multipliers.
package fp32_pkg;

  localparam int          BIAS     = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam int          SIGN_POS = 31;
  localparam int          EXP_MSB  = 30;
  localparam int          EXP_LSB  = 23;
  localparam int          FRAC_MSB = 22;
  localparam int          FRAC_W   = 23;
  localparam int          SIG_W    = 24;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/drum_segment.sv
// DRUM segment extractor: K-bit window under the leading one,
// with the LSB forced high when discarded bits are nonzero.
module drum_segment #(
  parameter int K = 8
) (
  input  logic [23:0]  m,
  output logic [K-1:0] seg,
  output logic [4:0]   sh
);

  logic [4:0]  t;
  logic [23:0] win;
  logic        sticky;

  always_comb begin
    t = '0;
    for (int i = 0; i < 24; i++) begin
      if (m[i]) t = 5'(i);
    end
  end

  always_comb begin
    sh = '0;
    if (32'(t) >= K) sh = t - 5'(K - 1);
  end

  assign win    = m >> sh;
  assign sticky = |(m & ~({24{1'b1}} << sh));
  assign seg    = win[K-1:0] | {{(K-1){1'b0}}, sticky};

endmodule

// File: rtl/mult_drum.sv
// FP32 multiplier with a DRUM approximate significand product.
// Combinational datapath, one output register stage.
module mult_drum
  import fp32_pkg::*;
#(
  parameter int K = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow
);

  fp32_t a, b;
  logic [23:0] m_a, m_b;
  logic [K-1:0] seg_a, seg_b;
  logic [4:0] sh_a, sh_b;
  logic [2*K-1:0] core;
  logic [5:0] sh_sum;
  logic [47:0] p;
  logic signed [9:0] e_raw, e_norm;
  logic [22:0] frac;
  logic zero, exc, ovf, unf;
  logic [31:0] res_d;

  assign a   = a_operand;
  assign b   = b_operand;
  assign m_a = {a.exp != 8'd0, a.frac};
  assign m_b = {b.exp != 8'd0, b.frac};

  drum_segment #(.K(K)) u_seg_a (
    .m   (m_a),
    .seg (seg_a),
    .sh  (sh_a)
  );

  drum_segment #(.K(K)) u_seg_b (
    .m   (m_b),
    .seg (seg_b),
    .sh  (sh_b)
  );

  assign core   = seg_a * seg_b;
  assign sh_sum = {1'b0, sh_a} + {1'b0, sh_b};
  assign p      = 48'(core) << sh_sum;

  assign e_raw  = 10'(a.exp) + 10'(b.exp) - 10'(BIAS);
  assign e_norm = p[47] ? e_raw + 10'sd1 : e_raw;
  assign frac   = p[47] ? p[46:24] : p[45:23];

  // A zero operand suppresses range flags but not Exception
  assign zero = (m_a == 24'd0) || (m_b == 24'd0);
  assign exc  = (a.exp == EXP_MAX) || (b.exp == EXP_MAX);
  assign ovf  = !zero && (e_norm >= 10'sd255);
  assign unf  = !zero && (e_norm <= 10'sd0);

  always_comb begin
    res_d = {a.sign ^ b.sign, e_norm[7:0], frac};
    if (zero || exc || ovf || unf) res_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      Exception <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      result    <= res_d;
      Exception <= exc;
      Overflow  <= ovf;
      Underflow <= unf;
    end
  end

endmodule

// File: tb/tb_mult_drum.sv
// Bench for mult_drum: directed cases plus random operands
// against an arithmetic model of the DRUM product.
module tb_mult_drum;

  localparam int K = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_operand = '0;
  logic [31:0] b_operand = '0;
  logic [31:0] result;
  logic        Exception, Overflow, Underflow;
  logic [34:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  mult_drum #(.K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_operand (a_operand),
    .b_operand (b_operand),
    .result    (result),
    .Exception (Exception),
    .Overflow  (Overflow),
    .Underflow (Underflow)
  );

  always #5 clk = ~clk;

  assign obs = {Exception, Overflow, Underflow, result};

  task automatic check(input string tag, input logic [34:0] got,
                       input logic [34:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void drum(input longint m, output longint seg,
                               output int sh);
    int t = 0;
    while (t < 23 && (m >> (t + 1)) != 0) t++;
    if (t >= K) begin
      sh  = t - K + 1;
      seg = m >> sh;
      if ((m % (64'sd1 << sh)) != 0) seg = seg | 64'sd1;
    end else begin
      sh  = 0;
      seg = m;
    end
  endfunction

  function automatic logic [34:0] model(input logic [31:0] a,
                                        input logic [31:0] b);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    longint ma = (ea != 0 ? 64'sh800000 : 64'sd0) + longint'(a[22:0]);
    longint mb = (eb != 0 ? 64'sh800000 : 64'sd0) + longint'(b[22:0]);
    bit exc = (ea == 255) || (eb == 255);
    longint sa, sb, p, frac;
    int sha, shb, e;
    bit ovf, unf;
    if (ma == 0 || mb == 0) return {exc, 34'h0};
    drum(ma, sa, sha);
    drum(mb, sb, shb);
    p = sa * sb * (64'sd1 << (sha + shb));
    e = ea + eb - 127;
    if (p >= (64'sd1 << 47)) begin
      frac = (p >> 24) % (64'sd1 << 23);
      e++;
    end else begin
      frac = (p >> 23) % (64'sd1 << 23);
    end
    ovf = e >= 255;
    unf = e <= 0;
    if (exc || ovf || unf) return {exc, ovf, unf, 32'h0};
    return {3'b000, a[31] ^ b[31], 8'(e), 23'(frac)};
  endfunction

  function automatic real fp_val(input logic [31:0] x);
    int  e = int'(x[30:23]);
    real m = (e != 0 ? 1.0 : 0.0) + real'(x[22:0]) / 8388608.0;
    return m * (2.0 ** (e - 127));
  endfunction

  task automatic apply(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    a_operand = a;
    b_operand = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 9))
      0: ;
      1: x[30:0] = '0;
      2: x[30:23] = 8'h00;
      3: x[30:23] = 8'hFF;
      default: x[30:23] = 8'($urandom_range(64, 190));
    endcase
    return x;
  endfunction

  initial begin
    real err;
    logic [31:0] ra, rb;

    a_operand = 32'h40400000;
    b_operand = 32'h40A00000;
    repeat (3) @(negedge clk);
    check("reset_hold", obs, 35'h0);
    reset = 1'b0;

    apply(32'h45800000, 32'h45800000);
    check("pow2_4096", obs, {3'b000, 32'h4B800000});
    check("pow2_model", obs, model(32'h45800000, 32'h45800000));

    apply(32'h40400000, 32'hC0A00000);
    check("three_x_m5", obs, {3'b000, 32'hC1700000});

    apply(32'h00000000, 32'h00000000);
    check("zero_zero", obs, 35'h0);

    apply(32'hC1526666, 32'h00000000);
    check("x_zero", obs, 35'h0);

    apply(32'h7F800000, 32'h7F800000);
    check("inf_inf", obs, {3'b110, 32'h0});

    apply(32'h00800000, 32'h00180000);
    check("underflow", obs, {3'b001, 32'h0});

    apply(32'h4234851F, 32'h427C851F);
    check("approx_se", 35'(result[31:23]), 35'(9'h08A));
    check("approx_model", obs, model(32'h4234851F, 32'h427C851F));
    err = fp_val(result) - fp_val(32'h453210E9);
    if (err < 0.0) err = -err;
    err = err / fp_val(32'h453210E9);
    check("approx_err", 35'(err < 2.0 ** (-(K - 1))), 35'(1));

    apply(32'h40400000, 32'hC0A00000);
    check("pre_reset", obs, {3'b000, 32'hC1700000});
    reset = 1'b1;
    #1;
    check("async_reset", obs, 35'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      ra = rand_op();
      rb = rand_op();
      apply(ra, rb);
      check("random", obs, model(ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
